ysyx_rf_scoreboard: RTL and testbench

- Register scoreboard that sequences instruction issue from the IDU into the EXU.
- Keeps a saturating pending-write counter per architectural register (4-bit index, 16 regs).
- Drives the `rf_table` busy vector and the operand-hazard flags the IDU consumes, taking EXU forwarding into account.
- Back-pressures issue when a destination counter would overflow, and clears all in-flight state on a pipeline flush.

---
 rtl/ysyx_rf_scoreboard.sv | 109 ++++++++++
 tb/tb_ysyx_rf_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_rf_scoreboard.sv
// Register scoreboard between IDU and EXU: per-register saturating pending-write
// counters, busy table, forwarding-aware operand hazards and issue back-pressure.

module ysyx_rf_cnt #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt
);

   // issue_ready keeps inc away from a full counter, so only the empty case is guarded
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          cnt <= '0;
      else if (flush)                    cnt <= '0;
      else if (inc && !dec)              cnt <= cnt + CNT_W'(1);
      else if (dec && !inc && cnt != '0) cnt <= cnt - CNT_W'(1);
   end

endmodule

module ysyx_rf_scoreboard #(
   parameter int NR_REG = 16,
   parameter int CNT_W  = 2,
   parameter int TOT_W  = 6,
   localparam int IDX_W = $clog2(NR_REG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic              issue_wen,
   input  logic [IDX_W-1:0]  issue_rd,
   output logic              issue_ready,
   input  logic              wb_valid,
   input  logic [IDX_W-1:0]  wb_rd,
   input  logic              flush,
   input  logic              fwd_valid,
   input  logic [IDX_W-1:0]  fwd_rd,
   input  logic [IDX_W-1:0]  rs1,
   input  logic [IDX_W-1:0]  rs2,
   output logic [NR_REG-1:0] rf_table,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic [TOT_W-1:0]  inflight,
   output logic              empty,
   output logic              err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [TOT_W-1:0] TOT_MAX = '1;

   logic [NR_REG-1:0][CNT_W-1:0] cnt;
   logic                         inc, dec, undf, dec_eff;
   logic [TOT_W-1:0]             cnt_sum;

   assign dec = wb_valid & (wb_rd != '0);
   assign inc = issue_valid & issue_ready & issue_wen & (issue_rd != '0);

   // a dec on an empty counter is dropped unless an inc to the same reg pairs with it
   assign undf    = dec & (cnt[wb_rd] == '0) & ~(inc & (issue_rd == wb_rd));
   assign dec_eff = dec & ~undf;

   assign issue_ready = ~(issue_wen & (issue_rd != '0) & (cnt[issue_rd] == CNT_MAX)
                          & ~(dec & (wb_rd == issue_rd)))
                      & ~((inflight == TOT_MAX) & ~dec)
                      & ~flush;

   // reg 0 never sees inc/dec, so its counter and busy bit stay zero
   for (genvar g = 0; g < NR_REG; g++) begin : g_reg
      ysyx_rf_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .inc   (inc & (issue_rd == IDX_W'(g))),
         .dec   (dec & (wb_rd == IDX_W'(g))),
         .cnt   (cnt[g])
      );
      assign rf_table[g] = |cnt[g];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight <= '0;
         err      <= 1'b0;
      end else if (flush) begin
         inflight <= '0;
      end else begin
         inflight <= inflight + TOT_W'(inc) - TOT_W'(dec_eff);
         if (undf) err <= 1'b1;
      end
   end

   assign empty = (inflight == '0);

   // a same-cycle writeback leaves busy set; the EXU forward path masks it instead
   assign rs1_busy = rf_table[rs1] & ~(fwd_valid & (fwd_rd == rs1));
   assign rs2_busy = rf_table[rs2] & ~(fwd_valid & (fwd_rd == rs2));

   always_comb begin
      cnt_sum = '0;
      for (int i = 0; i < NR_REG; i++) cnt_sum = cnt_sum + TOT_W'(cnt[i]);
   end

   a_inflight_sum: assert property (@(posedge clk) disable iff (!rst) inflight == cnt_sum);

endmodule

// File: tb/tb_ysyx_rf_scoreboard.sv
// Bench for ysyx_rf_scoreboard: directed scenarios plus random traffic checked
// against an array-of-counts reference model.

module tb_ysyx_rf_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_wen, wb_valid, flush, fwd_valid;
   logic [3:0]  issue_rd, wb_rd, fwd_rd, rs1, rs2;
   logic        issue_ready, rs1_busy, rs2_busy, empty, err;
   logic [15:0] rf_table;
   logic [5:0]  inflight;

   int mcnt[16];
   bit merr;
   int nchk = 0;
   int nbad = 0;

   ysyx_rf_scoreboard dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
      .issue_ready(issue_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .rs1(rs1), .rs2(rs2),
      .rf_table(rf_table), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .inflight(inflight), .empty(empty), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int msum();
      int s = 0;
      foreach (mcnt[i]) s += mcnt[i];
      return s;
   endfunction

   function automatic logic [15:0] mtab();
      logic [15:0] t;
      foreach (mcnt[i]) t[i] = (mcnt[i] != 0);
      return t;
   endfunction

   function automatic bit mdec();
      return wb_valid && wb_rd != 0;
   endfunction

   function automatic bit mready();
      return !(issue_wen && issue_rd != 0 && mcnt[issue_rd] == 3 && !(mdec() && wb_rd == issue_rd))
          && !(msum() == 63 && !mdec()) && !flush;
   endfunction

   task automatic mreset();
      foreach (mcnt[i]) mcnt[i] = 0;
      merr = 0;
   endtask

   task automatic idle();
      issue_valid = 0; issue_wen = 0; issue_rd = 0;
      wb_valid = 0; wb_rd = 0; flush = 0;
      fwd_valid = 0; fwd_rd = 0; rs1 = 0; rs2 = 0;
   endtask

   task automatic cmp_model();
      logic [15:0] t;
      t = mtab();
      chk("ready", issue_ready, mready());
      chk("rf_table", rf_table, t);
      chk("inflight", inflight, msum());
      chk("empty", empty, msum() == 0);
      chk("err", err, merr);
      chk("rs1_busy", rs1_busy, t[rs1] && !(fwd_valid && fwd_rd == rs1));
      chk("rs2_busy", rs2_busy, t[rs2] && !(fwd_valid && fwd_rd == rs2));
   endtask

   task automatic tick();
      bit inc;
      @(posedge clk);
      inc = issue_valid && mready() && issue_wen && issue_rd != 0;
      if (flush) begin
         foreach (mcnt[i]) mcnt[i] = 0;
      end else begin
         if (inc) mcnt[issue_rd]++;
         if (mdec()) begin
            if (mcnt[wb_rd] == 0) merr = 1;
            else mcnt[wb_rd]--;
         end
      end
      @(negedge clk);
   endtask

   task automatic cyc();
      #1 cmp_model();
      tick();
   endtask

   initial begin
      idle();
      mreset();
      rs1 = 5;
      rst = 1;
      #2 rst = 0;
      #1;
      chk("rst_rf_table", rf_table, 16'h0000);
      chk("rst_inflight", inflight, 0);
      chk("rst_empty", empty, 1);
      chk("rst_err", err, 0);
      chk("rst_ready", issue_ready, 1);
      chk("rst_rs1_busy", rs1_busy, 0);
      @(negedge clk) rst = 1;
      idle();

      // single issue / writeback
      issue_valid = 1; issue_wen = 1; issue_rd = 5; cyc(); idle();
      #1 chk("t1_rf_table", rf_table, 16'h0020);
      chk("t1_inflight", inflight, 1);
      chk("t1_empty", empty, 0);
      wb_valid = 1; wb_rd = 5; cyc(); idle();
      #1 chk("t1_rf_clear", rf_table, 16'h0000);
      chk("t1_empty2", empty, 1);

      // saturation on rd=3
      issue_valid = 1; issue_wen = 1; issue_rd = 3;
      repeat (3) cyc();
      #1 chk("t2_ready_full", issue_ready, 0);
      wb_valid = 1; wb_rd = 3;
      #1 chk("t2_ready_wb", issue_ready, 1);
      cyc(); idle();
      #1 chk("t2_inflight", inflight, 3);
      chk("t2_rf_table", rf_table, 16'h0008);
      wb_valid = 1; wb_rd = 3; repeat (3) cyc(); idle();

      // forwarding masks busy
      issue_valid = 1; issue_wen = 1; issue_rd = 7; cyc(); idle();
      rs1 = 7; rs2 = 0; fwd_valid = 1; fwd_rd = 7;
      #1 chk("t3_rs1_fwd", rs1_busy, 0);
      chk("t3_rs2_zero", rs2_busy, 0);
      fwd_valid = 0;
      #1 chk("t3_rs1_busy", rs1_busy, 1);
      chk("t3_rs2_zero2", rs2_busy, 0);
      cyc(); idle();
      wb_valid = 1; wb_rd = 7; cyc(); idle();

      // reg 0 never tracked
      issue_valid = 1; issue_wen = 1; issue_rd = 0; cyc(); idle();
      wb_valid = 1; wb_rd = 0; cyc(); idle();
      #1 chk("t4_rf_table", rf_table, 16'h0000);
      chk("t4_inflight", inflight, 0);
      chk("t4_err", err, 0);

      // flush discards in-flight writes and a concurrent issue
      issue_valid = 1; issue_wen = 1;
      issue_rd = 2; cyc();
      issue_rd = 4; cyc();
      issue_rd = 9; cyc(); idle();
      #1 chk("t5_inflight", inflight, 3);
      chk("t5_rf_table", rf_table, 16'h0214);
      flush = 1; issue_valid = 1; issue_wen = 1; issue_rd = 6;
      #1 chk("t5_ready_flush", issue_ready, 0);
      cyc(); idle();
      #1 chk("t5_rf_clear", rf_table, 16'h0000);
      chk("t5_inflight0", inflight, 0);

      // underflow sets sticky err
      #1 rst = 0;
      #1 mreset(); rst = 1;
      wb_valid = 1; wb_rd = 8; cyc(); idle();
      #1 chk("t6_err", err, 1);
      chk("t6_rf_table", rf_table, 16'h0000);
      chk("t6_inflight", inflight, 0);
      issue_valid = 1; issue_wen = 1; issue_rd = 1; cyc(); idle();
      wb_valid = 1; wb_rd = 1; cyc(); idle();
      #1 chk("t6_err_sticky", err, 1);

      // asynchronous reset mid-cycle
      issue_valid = 1; issue_wen = 1; issue_rd = 2; cyc(); idle();
      #2 rst = 0;
      #1 chk("t7_async_rf", rf_table, 16'h0000);
      chk("t7_async_err", err, 0);
      chk("t7_async_infl", inflight, 0);
      mreset();
      @(negedge clk) rst = 1;

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         issue_valid = 1'($urandom_range(0, 1));
         issue_wen   = ($urandom_range(0, 3) != 0);
         issue_rd    = 4'($urandom_range(0, 5));
         wb_valid    = ($urandom_range(0, 2) == 0);
         wb_rd       = 4'($urandom_range(0, 5));
         flush       = ($urandom_range(0, 40) == 0);
         fwd_valid   = 1'($urandom_range(0, 1));
         fwd_rd      = 4'($urandom_range(0, 5));
         rs1         = 4'($urandom_range(0, 6));
         rs2         = 4'($urandom_range(0, 15));
         cyc();
      end
      idle();
      cmp_model();

      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end

endmodule
